// File: rtl/be_sweep_ctrl_pkg.sv
// ============================================================================
// Module      : be_pkg
// Description : Shared state encoding, table-width derivation and parameter
//               limits for the boolean-equation sweep controller.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package be_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam int N_IN_MIN   = 1;
    localparam int N_IN_MAX   = 6;
    localparam int SETTLE_MIN = 0;
    localparam int SETTLE_MAX = 15;
    localparam int CNT_W      = 4;

    function automatic int tbl_w(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic bit params_ok(input int n_in, input int settle);
        return (n_in >= N_IN_MIN) && (n_in <= N_IN_MAX) &&
               (settle >= SETTLE_MIN) && (settle <= SETTLE_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/be_sweep_ctrl_if.sv
// ============================================================================
// Module      : be_sweep_ctrl_if
// Description : Host/evaluator-facing signal bundle of the sweep controller.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface be_sweep_ctrl_if
    import be_pkg::*;
#(
    parameter int N_IN = 4
);
    localparam int TBL_W = tbl_w(N_IN);

    logic               start;
    logic               abort;
    logic [TBL_W-1:0]   expect_tbl;
    logic [N_IN-1:0]    vec;
    logic               z_in;
    logic               busy;
    logic               done;
    logic [TBL_W-1:0]   table_out;
    logic [N_IN:0]      mismatch_cnt;
    logic               pass;

    // master = host plus evaluator side, slave = the controller
    modport master (
        output start, abort, expect_tbl, z_in,
        input  vec, busy, done, table_out, mismatch_cnt, pass
    );

    modport slave (
        input  start, abort, expect_tbl, z_in,
        output vec, busy, done, table_out, mismatch_cnt, pass
    );

endinterface

`default_nettype wire

// File: rtl/be_sweep_ctrl.sv
// ============================================================================
// Module      : be_sweep_ctrl
// Description : Walks every input vector through an external evaluator,
//               builds the measured truth table and scores it against a golden.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module be_sweep_ctrl
    import be_pkg::*;
#(
    parameter int N_IN       = 4,
    parameter int SETTLE_CYC = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    be_sweep_ctrl_if.slave   bus
);

    localparam int              TBL_W     = tbl_w(N_IN);
    localparam logic [N_IN-1:0] IDX_LAST  = N_IN'(TBL_W - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);
    localparam state_t          ST_AFTER_VEC = (SETTLE_CYC == 0) ? S_SAMPLE : S_WAIT;

    if (!params_ok(N_IN, SETTLE_CYC)) begin : g_param_check
        $error("be_sweep_ctrl: N_IN or SETTLE_CYC out of range");
    end

    state_t              state_q;
    logic [N_IN-1:0]     idx_q;
    logic [N_IN-1:0]     vec_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [TBL_W-1:0]    exp_q;
    logic [TBL_W-1:0]    tbl_q;
    logic [N_IN:0]       mm_q;
    logic                pass_q;
    logic                busy_q;
    logic                done_q;

    logic                w_diff;
    logic [N_IN:0]       mm_d;

    assign w_diff = bus.z_in ^ exp_q[idx_q];
    assign mm_d   = mm_q + (N_IN+1)'(w_diff);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            tbl_q   <= '0;
            mm_q    <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.abort && busy_q) begin
            // abort wins over any capture happening on the same edge
            state_q <= S_IDLE;
            idx_q   <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
            tbl_q   <= '0;
            mm_q    <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        idx_q   <= '0;
                        vec_q   <= '0;
                        exp_q   <= bus.expect_tbl;
                        tbl_q   <= '0;
                        mm_q    <= '0;
                        pass_q  <= 1'b0;
                        cnt_q   <= SETTLE_LD;
                        busy_q  <= 1'b1;
                        state_q <= ST_AFTER_VEC;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    tbl_q[idx_q] <= bus.z_in;
                    mm_q         <= mm_d;
                    if (idx_q == IDX_LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (mm_d == '0);
                        state_q <= S_FINISH;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        vec_q   <= idx_q + 1'b1;
                        cnt_q   <= SETTLE_LD;
                        state_q <= ST_AFTER_VEC;
                    end
                end
                S_FINISH: begin
                    done_q  <= 1'b0;
                    vec_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.vec          = vec_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.table_out    = tbl_q;
    assign bus.mismatch_cnt = mm_q;
    assign bus.pass         = pass_q;

endmodule

`default_nettype wire

// File: tb/tb_be_sweep_ctrl.sv
// ============================================================================
// Module      : tb_be_sweep_ctrl
// Description : Scoreboard bench: stimulus queues expected sweep results,
//               monitors pop and compare them on every done pulse.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_be_sweep_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit zmode  = 1'b0;
    int acc_b  = 0;

    be_sweep_ctrl_if #(.N_IN(4)) ifa ();
    be_sweep_ctrl_if #(.N_IN(4)) ifb ();

    // evaluator under sweep: z = a ^ d, or stuck-at-0 for instance A
    assign ifa.z_in = zmode ? 1'b0 : (ifa.vec[3] ^ ifa.vec[0]);
    assign ifb.z_in = ifb.vec[3] ^ ifb.vec[0];

    be_sweep_ctrl #(.N_IN(4), .SETTLE_CYC(2)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    be_sweep_ctrl #(.N_IN(4), .SETTLE_CYC(0)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    typedef struct {
        logic [15:0] tbl;
        logic [4:0]  mm;
        logic        pass;
        int          done_cyc;
        int          busy_cyc;
        string       name;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic score(input string tag, input exp_t e, input logic [15:0] tbl,
                         input logic [4:0] mm, input logic p, input int busy_n);
        chk({tag, "_", e.name, "_table"}, 32'(tbl), 32'(e.tbl));
        chk({tag, "_", e.name, "_mm"}, 32'(mm), 32'(e.mm));
        chk({tag, "_", e.name, "_pass"}, 32'(p), 32'(e.pass));
        chk({tag, "_", e.name, "_done_cycle"}, 32'(cyc), 32'(e.done_cyc));
        chk({tag, "_", e.name, "_busy_len"}, 32'(busy_n), 32'(e.busy_cyc));
    endtask

    initial begin : mon_a
        int busy_n;
        exp_t e;
        busy_n = 0;
        forever begin
            @(negedge clk);
            if (ifa.busy) begin
                busy_n++;
            end else begin
                if (ifa.done) begin
                    if (qa.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL A_unexpected_done: got done=1 expected none at cycle %0d", cyc);
                    end else begin
                        e = qa.pop_front();
                        score("A", e, ifa.table_out, ifa.mismatch_cnt, ifa.pass, busy_n);
                    end
                end
                busy_n = 0;
            end
        end
    end

    initial begin : mon_b
        int busy_n;
        exp_t e;
        busy_n = 0;
        forever begin
            @(negedge clk);
            if (ifb.busy) begin
                busy_n++;
                chk("B_vec_step", 32'(ifb.vec), 32'(cyc - acc_b));
            end else begin
                if (ifb.done) begin
                    if (qb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL B_unexpected_done: got done=1 expected none at cycle %0d", cyc);
                    end else begin
                        e = qb.pop_front();
                        score("B", e, ifb.table_out, ifb.mismatch_cnt, ifb.pass, busy_n);
                    end
                end
                busy_n = 0;
            end
        end
    end

    task automatic start_a(input logic [15:0] gold, input logic [15:0] tbl,
                           input logic [4:0] mm, input logic p, input string name);
        exp_t e;
        ifa.expect_tbl = gold;
        ifa.start      = 1'b1;
        tick();
        ifa.start      = 1'b0;
        e = '{tbl: tbl, mm: mm, pass: p, done_cyc: cyc + 48, busy_cyc: 48, name: name};
        qa.push_back(e);
    endtask

    task automatic drain(input bit sel_b, input int budget);
        int n;
        n = 0;
        while (((sel_b ? qb.size() : qa.size()) != 0) && (n < budget)) begin
            tick();
            n++;
        end
        checks++;
        if ((sel_b ? qb.size() : qa.size()) != 0) begin
            errors++;
            $display("FAIL drain_timeout_%s: got %0d pending expected 0",
                     sel_b ? "B" : "A", sel_b ? qb.size() : qa.size());
        end
    endtask

    function automatic logic [31:0] snap_a();
        return {4'd0, ifa.busy, ifa.done, ifa.vec, ifa.table_out, ifa.mismatch_cnt, ifa.pass};
    endfunction

    initial begin : stim
        exp_t e;
        rst            = 1'b1;
        ifa.start      = 1'b0;
        ifa.abort      = 1'b0;
        ifa.expect_tbl = '0;
        ifb.start      = 1'b0;
        ifb.abort      = 1'b0;
        ifb.expect_tbl = '0;
        tick(3);
        chk("reset_state_A", snap_a(), 32'd0);
        chk("reset_state_B", {4'd0, ifb.busy, ifb.done, ifb.vec, ifb.table_out,
                              ifb.mismatch_cnt, ifb.pass}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: matching golden; golden changed after start must not matter
        start_a(16'h55AA, 16'h55AA, 5'd0, 1'b1, "c1");
        ifa.expect_tbl = 16'h0000;
        tick(2);
        chk("c1_busy", 32'(ifa.busy), 32'd1);
        drain(1'b0, 100);
        tick(3);
        chk("c1_hold", {11'd0, ifa.table_out, ifa.mismatch_cnt, ifa.pass}, {11'd0, 16'h55AA, 5'd0, 1'b1});

        // 2: one golden bit wrong
        start_a(16'h55AB, 16'h55AA, 5'd1, 1'b0, "c2");
        drain(1'b0, 100);

        // 3: evaluator stuck at 0 against all-ones golden
        zmode = 1'b1;
        start_a(16'hFFFF, 16'h0000, 5'd16, 1'b0, "c3");
        drain(1'b0, 100);
        zmode = 1'b0;

        // 4: abort at cycle 10 of a sweep
        ifa.expect_tbl = 16'h55AA;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        tick(9);
        chk("c4_pre_abort_table", 32'(ifa.table_out), 32'h0002);
        ifa.abort = 1'b1;
        tick();
        ifa.abort = 1'b0;
        chk("c4_after_abort", snap_a(), 32'd0);
        tick(60);

        // 5a: reset mid-sweep
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        tick(19);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("c5a_after_rst", snap_a(), 32'd0);
        tick(60);

        // 5b: start re-pulsed mid-sweep, held through FINISH, accepted after done
        start_a(16'h55AA, 16'h55AA, 5'd0, 1'b1, "c5b1");
        tick(4);
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        tick(24);
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        tick(18);
        chk("c5b_done_seen", 32'(ifa.done), 32'd1);
        ifa.expect_tbl = 16'h55AB;
        ifa.start = 1'b1;
        tick(2);
        ifa.start = 1'b0;
        e = '{tbl: 16'h55AA, mm: 5'd1, pass: 1'b0, done_cyc: cyc + 48, busy_cyc: 48, name: "c5b2"};
        qa.push_back(e);
        chk("c5b_restart_busy", 32'(ifa.busy), 32'd1);
        drain(1'b0, 100);

        // 6: zero settle time
        ifb.expect_tbl = 16'h55AA;
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        acc_b = cyc;
        e = '{tbl: 16'h55AA, mm: 5'd0, pass: 1'b1, done_cyc: cyc + 16, busy_cyc: 16, name: "c6"};
        qb.push_back(e);
        drain(1'b1, 40);
        tick(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
